// File: rtl/seven_seg_pkg.sv
// Package: seven_seg_pkg
// Purpose: shared types and the hex-to-segment table for the scanned
//          seven-segment driver.
// Contents:
//   seg_t      - 7-bit segment vector {g,f,e,d,c,b,a}, active-low
//   SEG_BLANK  - all segments off
//   hex_to_seg - nibble to active-low segment pattern
package seven_seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    seg_t seg;
    case (nibble)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_segment_scan_driver_if.sv
// Interface: seven_segment_scan_driver_if
// Purpose: bundles the user-side data/strobe inputs and the display-pin
//          outputs of the scan driver.
// Signals:
//   digits_i  4*N_DIGITS  hex nibbles, digit 0 in bits [3:0]
//   dp_i      N_DIGITS    decimal point request, 1 = lit
//   enable_i  N_DIGITS    per-digit enable
//   load_i    1           capture strobe
//   seg_o     7           segments {g..a}, active-low
//   dp_o      1           decimal point, active-low
//   anode_o   8           digit select, active-low
//   frame_o   1           frame start pulse
// Modports: master = user logic, slave = driver.
interface seven_segment_scan_driver_if #(
  parameter int N_DIGITS = 8
);
  logic [4*N_DIGITS-1:0] digits_i;
  logic [N_DIGITS-1:0]   dp_i;
  logic [N_DIGITS-1:0]   enable_i;
  logic                  load_i;
  logic [6:0]            seg_o;
  logic                  dp_o;
  logic [7:0]            anode_o;
  logic                  frame_o;

  modport master (
    output digits_i, dp_i, enable_i, load_i,
    input  seg_o, dp_o, anode_o, frame_o
  );

  modport slave (
    input  digits_i, dp_i, enable_i, load_i,
    output seg_o, dp_o, anode_o, frame_o
  );
endinterface

// File: rtl/hex_to_seven_seg.sv
// Module: hex_to_seven_seg
// Purpose: combinational hex nibble to active-low segment decode.
// Ports:
//   nibble  in   4  hex value
//   seg     out  7  {g,f,e,d,c,b,a}, active-low
module hex_to_seven_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seven_segment_scan_driver.sv
// Module: seven_segment_scan_driver
// Purpose: time-multiplexed driver for up to 8 seven-segment digits with
//          tear-free frame update and blanking at the start of every slot.
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  synchronous, active-high
//   bus    slave modport of seven_segment_scan_driver_if
// Parameters:
//   N_DIGITS      digits scanned (1..8), unused anodes held high
//   REFRESH_DIV   clk cycles per digit slot (>= 2)
//   BLANK_CYCLES  cycles at slot start with all anodes off (< REFRESH_DIV)
// Build option:
//   SEVEN_SEG_LEADING_ZERO_BLANK_EN - when defined, leading zero digits
//   (above digit 0) are blanked; otherwise every enabled digit is shown.
module seven_segment_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input logic clk,
  input logic reset,
  seven_segment_scan_driver_if.slave bus
);

  localparam int PS_W  = $clog2(REFRESH_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic [PS_W-1:0]       prescaler;
  logic [IDX_W-1:0]      idx;

  logic [4*N_DIGITS-1:0] pend_digits, disp_digits;
  logic [N_DIGITS-1:0]   pend_dp, disp_dp;
  logic [N_DIGITS-1:0]   pend_en, disp_en;

  seg_t                  seg_q;
  logic                  dp_q;
  logic [7:0]            anode_q;
  logic                  frame_q;

  logic                  slot_end, frame_end, in_blank;
  logic [N_DIGITS-1:0]   lz_blank;
  logic [3:0]            sel_nib;
  logic                  sel_en, sel_dp, sel_lz;
  seg_t                  dec_seg;
  seg_t                  seg_n;
  logic                  dp_n;
  logic [7:0]            anode_n;
  logic                  drive_anode;

  assign slot_end  = (prescaler == PS_W'(REFRESH_DIV - 1));
  assign frame_end = slot_end && (idx == IDX_W'(N_DIGITS - 1));
  assign in_blank  = (prescaler < PS_W'(BLANK_CYCLES));

  // A digit is a leading zero when it is zero and every enabled digit
  // above it is zero too; disabled digits do not break the run.
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_blank   = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      lz_blank[k] = (k > 0) && disp_en[k] && (disp_digits[4*k +: 4] == 4'h0) && zero_above;
      if (disp_en[k] && (disp_digits[4*k +: 4] != 4'h0))
        zero_above = 1'b0;
    end
  end
`else
  assign lz_blank = '0;
`endif

  always_comb begin
    sel_nib = 4'h0;
    sel_en  = 1'b0;
    sel_dp  = 1'b0;
    sel_lz  = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (idx == IDX_W'(k)) begin
        sel_nib = disp_digits[4*k +: 4];
        sel_en  = disp_en[k];
        sel_dp  = disp_dp[k];
        sel_lz  = lz_blank[k];
      end
    end
  end

  hex_to_seven_seg u_dec (
    .nibble (sel_nib),
    .seg    (dec_seg)
  );

  // A blanked leading zero still pulls its anode low when its decimal
  // point is requested, so the dp is visible with segments off.
  always_comb begin
    seg_n       = SEG_BLANK;
    dp_n        = 1'b1;
    drive_anode = 1'b0;
    if (!in_blank && sel_en) begin
      if (sel_lz) begin
        if (sel_dp) begin
          drive_anode = 1'b1;
          dp_n        = 1'b0;
        end
      end else begin
        drive_anode = 1'b1;
        seg_n       = dec_seg;
        dp_n        = ~sel_dp;
      end
    end
    anode_n = 8'hFF;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (drive_anode && (idx == IDX_W'(k)))
        anode_n[k] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler   <= '0;
      idx         <= '0;
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_en     <= '0;
      disp_digits <= '0;
      disp_dp     <= '0;
      disp_en     <= '0;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
      anode_q     <= 8'hFF;
      frame_q     <= 1'b0;
    end else begin
      seg_q   <= seg_n;
      dp_q    <= dp_n;
      anode_q <= anode_n;
      frame_q <= frame_end;

      if (bus.load_i) begin
        pend_digits <= bus.digits_i;
        pend_dp     <= bus.dp_i;
        pend_en     <= bus.enable_i;
      end

      if (slot_end) begin
        prescaler <= '0;
        if (frame_end) begin
          idx <= '0;
          // A load landing on the boundary cycle bypasses pending.
          if (bus.load_i) begin
            disp_digits <= bus.digits_i;
            disp_dp     <= bus.dp_i;
            disp_en     <= bus.enable_i;
          end else begin
            disp_digits <= pend_digits;
            disp_dp     <= pend_dp;
            disp_en     <= pend_en;
          end
        end else begin
          idx <= idx + 1'b1;
        end
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  assign bus.seg_o   = seg_q;
  assign bus.dp_o    = dp_q;
  assign bus.anode_o = anode_q;
  assign bus.frame_o = frame_q;

endmodule
